// File: rtl/s_pipe_rca.sv
// s_pipe_rca -- skewed pipelined ripple-carry adder/subtractor.
//
// Each pipeline slot adds STAGE_BITS bits of the operands; the remaining
// operand bits, the finished low sum bits and the inter-stage carry travel
// with the beat. The final stage feeds the output register.
//
// Ports:
//   clk        rising-edge clock for all state
//   rst_n      synchronous active-low reset
//   in_valid   operand beat offered
//   in_ready   beat accepted this cycle (combinational)
//   a, b       signed WIDTH-bit operands
//   sub        0 = a+b, 1 = a-b, sampled with the beat
//   out_valid  result beat present
//   out_ready  downstream accepts result
//   out        signed WIDTH+1-bit result, never overflows
//   ovf        result not representable in WIDTH bits
module s_pipe_rca #(
   parameter int WIDTH      = 16,
   parameter int STAGE_BITS = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH:0]   out,
   output logic             ovf
);

   // Divisor guarded so a bad STAGE_BITS reaches the elaboration error below
   // instead of a divide-by-zero.
   localparam int STAGES = WIDTH / ((STAGE_BITS < 1) ? 1 : STAGE_BITS);
   localparam int IDXW   = $clog2(WIDTH);

   generate
      if (WIDTH < 2) begin : g_bad_width
         $error("s_pipe_rca: WIDTH must be >= 2");
      end
      if (STAGE_BITS < 1) begin : g_bad_stage
         $error("s_pipe_rca: STAGE_BITS must be >= 1");
      end else if ((WIDTH % STAGE_BITS) != 0) begin : g_bad_div
         $error("s_pipe_rca: STAGE_BITS must divide WIDTH");
      end
   endgenerate

   // Slot k holds the beat waiting to be processed by stage k.
   logic             v_q   [STAGES];
   logic [WIDTH-1:0] a_q   [STAGES];
   logic [WIDTH-1:0] bp_q  [STAGES];
   logic [WIDTH-1:0] sum_q [STAGES];
   logic             c_q   [STAGES];

   logic [WIDTH-1:0] nsum  [STAGES];
   logic             nc    [STAGES];
   logic             c_msb;
   logic             advance;

   logic             cy;
   logic [WIDTH-1:0] s;
   logic [IDXW-1:0]  bit_i;
   logic             ai;
   logic             bi;

   assign advance  = !out_valid || out_ready;
   assign in_ready = advance && rst_n;

   // Ripple each stage's window; carry into the MSB is captured in the last
   // stage for the overflow flag.
   always_comb begin
      c_msb = 1'b0;
      cy    = 1'b0;
      s     = '0;
      bit_i = '0;
      ai    = 1'b0;
      bi    = 1'b0;
      for (int unsigned k = 0; k < STAGES; k++) begin
         s  = sum_q[k];
         cy = c_q[k];
         for (int unsigned i = 0; i < STAGE_BITS; i++) begin
            bit_i    = IDXW'(k * STAGE_BITS + i);
            ai       = a_q[k][bit_i];
            bi       = bp_q[k][bit_i];
            s[bit_i] = ai ^ bi ^ cy;
            if (bit_i == IDXW'(WIDTH - 1))
               c_msb = cy;
            cy = (ai & bi) | (cy & (ai ^ bi));
         end
         nsum[k] = s;
         nc[k]   = cy;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int unsigned k = 0; k < STAGES; k++) begin
            v_q[k]   <= 1'b0;
            a_q[k]   <= '0;
            bp_q[k]  <= '0;
            sum_q[k] <= '0;
            c_q[k]   <= 1'b0;
         end
         out_valid <= 1'b0;
         out       <= '0;
         ovf       <= 1'b0;
      end else if (advance) begin
         v_q[0]   <= in_valid;
         a_q[0]   <= a;
         bp_q[0]  <= sub ? ~b : b;
         sum_q[0] <= '0;
         c_q[0]   <= sub;
         for (int unsigned k = 1; k < STAGES; k++) begin
            v_q[k]   <= v_q[k-1];
            a_q[k]   <= a_q[k-1];
            bp_q[k]  <= bp_q[k-1];
            sum_q[k] <= nsum[k-1];
            c_q[k]   <= nc[k-1];
         end
         out_valid <= v_q[STAGES-1];
         // out/ovf only load on a real beat so they hold across bubbles.
         if (v_q[STAGES-1]) begin
            out <= {a_q[STAGES-1][WIDTH-1] ^ bp_q[STAGES-1][WIDTH-1] ^ nc[STAGES-1],
                    nsum[STAGES-1]};
            ovf <= c_msb ^ nc[STAGES-1];
         end
      end
   end

endmodule

// File: tb/tb_s_pipe_rca.sv
module tb_s_pipe_rca;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid, in_ready, sub, out_valid, out_ready, ovf;
   logic [15:0] a, b;
   logic [16:0] out;

   logic        in_valid8, in_ready8, sub8, out_valid8, out_ready8, ovf8;
   logic [7:0]  a8, b8;
   logic [8:0]  out8;

   int checks = 0;
   int errors = 0;

   logic [16:0] q_out[$];
   logic        q_ovf[$];

   logic        prev_stall = 1'b0;
   logic [16:0] prev_out;
   logic        prev_ovf;

   logic [15:0] va[8];
   logic [15:0] vb[8];
   logic        vs[8];

   always #5 clk = ~clk;

   s_pipe_rca #(.WIDTH(16), .STAGE_BITS(4)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
      .out(out), .ovf(ovf)
   );

   s_pipe_rca #(.WIDTH(8), .STAGE_BITS(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
      .a(a8), .b(b8), .sub(sub8), .out_valid(out_valid8), .out_ready(out_ready8),
      .out(out8), .ovf(ovf8)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference: exact integer sum/difference, then truncate to 17 bits.
   function automatic void model(input logic [15:0] x, input logic [15:0] y, input logic s,
                                 output logic [16:0] o, output logic v);
      int sx, sy, r;
      sx = $signed(x);
      sy = $signed(y);
      r  = s ? (sx - sy) : (sx + sy);
      o  = r[16:0];
      v  = (r > 32767) || (r < -32768);
   endfunction

   // Scoreboard and handshake-rule monitor, sampled mid-cycle.
   always @(negedge clk) begin
      logic [16:0] eo;
      logic        ev;
      if (!rst_n) begin
         q_out.delete();
         q_ovf.delete();
         check("in_ready_during_reset", {31'b0, in_ready}, 32'd0);
         prev_stall = 1'b0;
      end else begin
         check("in_ready_rule", {31'b0, in_ready}, {31'b0, (!out_valid || out_ready)});
         if (prev_stall) begin
            check("stall_hold_valid", {31'b0, out_valid}, 32'd1);
            check("stall_hold_out", {15'b0, out}, {15'b0, prev_out});
            check("stall_hold_ovf", {31'b0, ovf}, {31'b0, prev_ovf});
         end
         if (out_valid && out_ready) begin
            if (q_out.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_result: got %h expected none", out);
            end else begin
               eo = q_out.pop_front();
               ev = q_ovf.pop_front();
               check("sb_out", {15'b0, out}, {15'b0, eo});
               check("sb_ovf", {31'b0, ovf}, {31'b0, ev});
            end
         end
         if (in_valid && in_ready) begin
            model(a, b, sub, eo, ev);
            q_out.push_back(eo);
            q_ovf.push_back(ev);
         end
         prev_stall = out_valid && !out_ready;
         prev_out   = out;
         prev_ovf   = ovf;
      end
   end

   // Single beat with literal expectation and latency measurement.
   task automatic run_vec(input logic [15:0] xa, input logic [15:0] xb, input logic xs,
                          input logic [16:0] eo, input logic ev, input string name);
      int n;
      @(posedge clk); #1;
      in_valid = 1'b1; a = xa; b = xb; sub = xs;
      @(posedge clk); #1;
      in_valid = 1'b0;
      n = 0;
      while (!out_valid && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      check({name, "_latency"}, n, 32'd4);
      check({name, "_out"}, {15'b0, out}, {15'b0, eo});
      check({name, "_ovf"}, {31'b0, ovf}, {31'b0, ev});
   endtask

   // Stream the vector table; mode 0 stalls cycles 5..7, mode 1 stalls every third cycle.
   task automatic stream(input int mode);
      int idx;
      int guard;
      idx = 0;
      for (int c = 0; c < 60 && idx < 8; c++) begin
         out_ready = (mode == 0) ? !(c >= 5 && c <= 7) : ((c % 3) != 1);
         in_valid  = 1'b1;
         a = va[idx]; b = vb[idx]; sub = vs[idx];
         @(negedge clk);
         if (mode == 0 && c < 10)
            check($sformatf("stall_in_ready_c%0d", c), {31'b0, in_ready},
                  {31'b0, !(c >= 5 && c <= 7)});
         if (in_ready) idx++;
         @(posedge clk); #1;
      end
      check("stream_all_accepted", idx, 32'd8);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      guard = 0;
      while (q_out.size() != 0 && guard < 50) begin
         @(posedge clk); #1;
         guard++;
      end
      check("stream_drained", q_out.size(), 32'd0);
   endtask

   initial begin
      int n;
      int seen;
      va = '{16'h0001, 16'h7FFF, 16'h8000, 16'hFFFF, 16'h1234, 16'h4000, 16'hABCD, 16'h0F0F};
      vb = '{16'h0002, 16'h7FFF, 16'h8000, 16'h0001, 16'h4321, 16'hC000, 16'h5432, 16'hF0F0};
      vs = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

      rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; sub = 1'b0; out_ready = 1'b1;
      in_valid8 = 1'b0; a8 = '0; b8 = '0; sub8 = 1'b0; out_ready8 = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_out_valid", {31'b0, out_valid}, 32'd0);
      check("reset_out", {15'b0, out}, 32'd0);
      check("reset_ovf", {31'b0, ovf}, 32'd0);
      check("reset_in_ready", {31'b0, in_ready}, 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      check("ready_after_release", {31'b0, in_ready}, 32'd1);

      run_vec(16'h7FFF, 16'h0001, 1'b0, 17'h08000, 1'b1, "pos_ovf");
      run_vec(16'h8000, 16'h0001, 1'b1, 17'h17FFF, 1'b1, "neg_ovf");
      run_vec(16'hFFFF, 16'hFFFF, 1'b0, 17'h1FFFE, 1'b0, "minus2");
      run_vec(16'h1234, 16'h1234, 1'b1, 17'h00000, 1'b0, "zero");

      stream(0);
      stream(1);

      // Reset with three beats in flight.
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         in_valid = 1'b1; a = va[i]; b = vb[i]; sub = vs[i];
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      check("midreset_out_valid", {31'b0, out_valid}, 32'd0);
      check("midreset_out", {15'b0, out}, 32'd0);
      check("midreset_ovf", {31'b0, ovf}, 32'd0);
      seen = 0;
      repeat (12) begin
         @(negedge clk);
         if (out_valid) seen++;
      end
      check("midreset_no_emerge", seen, 32'd0);

      // Single-stage 8-bit instance.
      @(posedge clk); #1;
      in_valid8 = 1'b1; a8 = 8'h80; b8 = 8'h80; sub8 = 1'b0;
      @(posedge clk); #1;
      in_valid8 = 1'b0;
      n = 0;
      while (!out_valid8 && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      check("w8_latency", n, 32'd1);
      check("w8_out", {23'b0, out8}, 32'h100);
      check("w8_ovf", {31'b0, ovf8}, 32'd1);

      repeat (3) @(posedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/s_pipe_rca.md
S_PIPE_RCA -- requirements
Module: s_pipe_rca

Interface
REQ-001 Parameter WIDTH, default 16: operand width in bits, signed two's complement, WIDTH >= 2.
REQ-002 Parameter STAGE_BITS, default 4: bits summed per pipeline stage; STAGES = WIDTH/STAGE_BITS.
REQ-003 The block SHALL fail elaboration if STAGE_BITS does not divide WIDTH or STAGE_BITS < 1.
REQ-004 The block SHALL use one clock; reset is synchronous and active-low.
REQ-005 clk  in  1  rising-edge clock for all state.
REQ-006 rst_n  in  1  synchronous active-low reset.
REQ-007 in_valid  in  1  operand beat offered.
REQ-008 in_ready  out  1  block accepts the beat this cycle.
REQ-009 a  in  WIDTH  signed operand A.
REQ-010 b  in  WIDTH  signed operand B.
REQ-011 sub  in  1  0 = A+B, 1 = A-B; sampled with the beat.
REQ-012 out_valid  out  1  result beat present.
REQ-013 out_ready  in  1  downstream accepts result.
REQ-014 out  out  WIDTH+1  signed result, sign-extended, never overflows.
REQ-015 ovf  out  1  result not representable in WIDTH bits.

Function
REQ-016 A beat SHALL transfer on input when in_valid && in_ready, and on output when out_valid && out_ready.
REQ-017 Effective operand B' = sub ? ~b : b; carry into stage 0 = sub.
REQ-018 Stage k (0..STAGES-1) SHALL ripple-add bits [k*STAGE_BITS +: STAGE_BITS] of A and B' with the carry registered from stage k-1; untouched upper operand bits and finished lower sum bits SHALL travel with the beat (skewed pipeline).
REQ-019 out[WIDTH-1:0] = low WIDTH bits of A + B' + sub; out[WIDTH] = A[WIDTH-1] ^ B'[WIDTH-1] ^ carry out of bit WIDTH-1.
REQ-020 ovf = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1.
REQ-021 Latency: out_valid SHALL rise exactly STAGES cycles after the accepting edge when not stalled; throughput one beat per cycle.
REQ-022 Pipeline advances when advance = !out_valid || out_ready; in_ready = advance && rst_n (combinational).
REQ-023 When advance is 0, all stage registers, out, ovf and out_valid SHALL hold; out/ovf SHALL stay stable while out_valid && !out_ready.
REQ-024 Bubbles SHALL propagate as invalid stage slots; a bubble may be squeezed only by a full-pipeline advance, never by partial compaction.
REQ-025 Results SHALL leave in acceptance order; no beat lost or duplicated under any out_ready pattern.
REQ-026 Simultaneous output accept and input accept in one cycle SHALL both complete.
REQ-027 out and ovf are don't-care-free: when out_valid = 0 they SHALL hold their last value (0 after reset).

Reset
REQ-028 With rst_n = 0 at a rising edge: every stage valid bit, out_valid, out and ovf SHALL become 0.
REQ-029 in_ready SHALL be 0 while rst_n = 0 and 1 in the first cycle after release.
REQ-030 Reset mid-operation SHALL discard all in-flight beats; none emerge after release.

Verification (WIDTH=16, STAGE_BITS=4, latency 4 unless stated)
REQ-031 a=0x7FFF, b=0x0001, sub=0, out_ready=1 -> 4 cycles later out=0x08000, ovf=1.
REQ-032 a=0x8000, b=0x0001, sub=1 -> out=0x17FFF (-32769), ovf=1.
REQ-033 a=0xFFFF, b=0xFFFF, sub=0 -> out=0x1FFFE (-2), ovf=0; a=0x1234, b=0x1234, sub=1 -> out=0x00000, ovf=0.
REQ-034 8 back-to-back beats with out_ready low for cycles 5-7 -> in_ready low in exactly those cycles, out stable, all 8 results in order.
REQ-035 3 beats in flight, rst_n low one cycle -> next cycle out_valid=0, out=0, ovf=0; no result emerges afterwards.
REQ-036 WIDTH=8, STAGE_BITS=8: a=0x80, b=0x80, sub=0 -> 1 cycle later out=0x100 (-256), ovf=1.
